// File: rtl/operand_fetch_stage_pkg.sv
// Shared types for the operand fetch stage: lane count, register indices,
// register file port bundles and the issued micro-op lane record.
package operand_fetch_stage_pkg;

   localparam int SUPER_SCALAR_WIDTH          = 2;
   localparam int PHYSICAL_REGISTER_FILE_SIZE = 64;
   localparam int PREG_W        = $clog2(PHYSICAL_REGISTER_FILE_SIZE);
   localparam int WORD_W        = 64;
   localparam int UOP_PAYLOAD_W = 64;

   typedef logic [WORD_W-1:0] Word;
   typedef logic [PREG_W-1:0] PregIndex;

   typedef struct packed {
      PregIndex index;
   } RegisterFileReadRequest;

   typedef struct packed {
      Word data;
   } RegisterFileReadResponse;

   typedef struct packed {
      logic     write_enable;
      PregIndex index;
      Word      data;
   } RegisterFileWriteRequest;

   typedef struct packed {
      logic                     lane_valid;
      PregIndex                 src0;
      PregIndex                 src1;
      PregIndex                 dst;
      logic [UOP_PAYLOAD_W-1:0] payload;
   } IssuedUop;

   // Empty lanes park their read ports on the zero register.
   function automatic PregIndex read_index(input logic     active,
                                           input PregIndex idx);
      return active ? idx : '0;
   endfunction

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// Resolves one source operand from the zero register, the snooped
// writeback ports (highest port wins) or the register file data.
module operand_bypass_mux
   import operand_fetch_stage_pkg::*;
(
   input  PregIndex                index_in,
   input  Word                     rf_data_in,
   input  RegisterFileWriteRequest wr_req_in [SUPER_SCALAR_WIDTH],
   output Word                     operand_out
);

   always_comb begin
      operand_out = rf_data_in;
      for (int p = 0; p < SUPER_SCALAR_WIDTH; p++) begin
         if (wr_req_in[p].write_enable &&
             (wr_req_in[p].index == index_in)) begin
            operand_out = wr_req_in[p].data;
         end
      end
      if (index_in == '0) begin
         operand_out = '0;
      end
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Two-stage operand fetch: S1 holds the issued bundle and reads the
// register file, S2 holds the bundle with bypass-resolved operands.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int PAYLOAD_WIDTH = UOP_PAYLOAD_W
) (
   input  logic                                         clk_in,
   input  logic                                         rst_in,
   input  logic                                         flush_in,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [SUPER_SCALAR_WIDTH-1:0]                in_lane_valid,
   input  logic [SUPER_SCALAR_WIDTH-1:0][PREG_W-1:0]    in_src0,
   input  logic [SUPER_SCALAR_WIDTH-1:0][PREG_W-1:0]    in_src1,
   input  logic [SUPER_SCALAR_WIDTH-1:0][PREG_W-1:0]    in_dst,
   input  logic [SUPER_SCALAR_WIDTH-1:0][PAYLOAD_WIDTH-1:0] in_payload,
   output RegisterFileReadRequest  rf_read0_req_out [SUPER_SCALAR_WIDTH],
   output RegisterFileReadRequest  rf_read1_req_out [SUPER_SCALAR_WIDTH],
   input  RegisterFileReadResponse rf_read0_resp_in [SUPER_SCALAR_WIDTH],
   input  RegisterFileReadResponse rf_read1_resp_in [SUPER_SCALAR_WIDTH],
   input  RegisterFileWriteRequest rf_write_req_in  [SUPER_SCALAR_WIDTH],
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [SUPER_SCALAR_WIDTH-1:0]                out_lane_valid,
   output logic [SUPER_SCALAR_WIDTH-1:0][PREG_W-1:0]    out_dst,
   output logic [SUPER_SCALAR_WIDTH-1:0][PAYLOAD_WIDTH-1:0] out_payload,
   output Word  [SUPER_SCALAR_WIDTH-1:0]                out_op0,
   output Word  [SUPER_SCALAR_WIDTH-1:0]                out_op1
);

   localparam int W = SUPER_SCALAR_WIDTH;

   logic                            s1_valid_d, s1_valid_q;
   IssuedUop [W-1:0]                s1_d, s1_q;

   logic                            s2_valid_d, s2_valid_q;
   logic [W-1:0]                    s2_lane_valid_d, s2_lane_valid_q;
   logic [W-1:0][PREG_W-1:0]        s2_dst_d, s2_dst_q;
   logic [W-1:0][PAYLOAD_WIDTH-1:0] s2_payload_d, s2_payload_q;
   Word  [W-1:0]                    s2_op0_d, s2_op0_q;
   Word  [W-1:0]                    s2_op1_d, s2_op1_q;

   PregIndex [W-1:0]                rd0_idx, rd1_idx;
   Word      [W-1:0]                op0_res, op1_res;

   logic                            s2_free;
   logic                            s1_advance;
   logic                            accept;

   // Flush blocks intake so the bundle presented that cycle is dropped.
   always_comb begin
      s2_free    = !s2_valid_q || out_ready;
      s1_advance = s1_valid_q && s2_free;
      in_ready   = !flush_in && (!s1_valid_q || s1_advance);
      accept     = in_valid && in_ready;
   end

   always_comb begin
      for (int i = 0; i < W; i++) begin
         rd0_idx[i] = read_index(s1_valid_q && s1_q[i].lane_valid,
                                 s1_q[i].src0);
         rd1_idx[i] = read_index(s1_valid_q && s1_q[i].lane_valid,
                                 s1_q[i].src1);
         rf_read0_req_out[i].index = rd0_idx[i];
         rf_read1_req_out[i].index = rd1_idx[i];
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_lane
      operand_bypass_mux u_byp0 (
         .index_in    (rd0_idx[i]),
         .rf_data_in  (rf_read0_resp_in[i].data),
         .wr_req_in   (rf_write_req_in),
         .operand_out (op0_res[i])
      );

      operand_bypass_mux u_byp1 (
         .index_in    (rd1_idx[i]),
         .rf_data_in  (rf_read1_resp_in[i].data),
         .wr_req_in   (rf_write_req_in),
         .operand_out (op1_res[i])
      );
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (flush_in) begin
         s1_valid_d = 1'b0;
      end else if (accept) begin
         s1_valid_d = 1'b1;
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end
      if (accept) begin
         for (int i = 0; i < W; i++) begin
            s1_d[i].lane_valid = in_lane_valid[i];
            s1_d[i].src0       = in_src0[i];
            s1_d[i].src1       = in_src1[i];
            s1_d[i].dst        = in_dst[i];
            s1_d[i].payload    = in_payload[i];
         end
      end
   end

   // S2 reloads whenever it is empty or draining, else it freezes.
   always_comb begin
      s2_valid_d      = s2_valid_q;
      s2_lane_valid_d = s2_lane_valid_q;
      s2_dst_d        = s2_dst_q;
      s2_payload_d    = s2_payload_q;
      s2_op0_d        = s2_op0_q;
      s2_op1_d        = s2_op1_q;
      if (flush_in) begin
         s2_valid_d = 1'b0;
      end else if (s2_free) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_advance) begin
         for (int i = 0; i < W; i++) begin
            s2_lane_valid_d[i] = s1_q[i].lane_valid;
            s2_dst_d[i]        = s1_q[i].dst;
            s2_payload_d[i]    = s1_q[i].payload;
         end
         s2_op0_d = op0_res;
         s2_op1_d = op1_res;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   always_ff @(posedge clk_in) begin
      s1_q            <= s1_d;
      s2_lane_valid_q <= s2_lane_valid_d;
      s2_dst_q        <= s2_dst_d;
      s2_payload_q    <= s2_payload_d;
      s2_op0_q        <= s2_op0_d;
      s2_op1_q        <= s2_op1_d;
   end

   always_comb begin
      out_valid      = s2_valid_q;
      out_lane_valid = s2_lane_valid_q;
      out_dst        = s2_dst_q;
      out_payload    = s2_payload_q;
      out_op0        = s2_op0_q;
      out_op1        = s2_op1_q;
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: bundle-level model with an
// in-bench register file, randomized traffic, writes, flushes and resets.
module tb_operand_fetch_stage;
   import operand_fetch_stage_pkg::*;

   localparam int W  = SUPER_SCALAR_WIDTH;
   localparam int PW = UOP_PAYLOAD_W;

   typedef struct {
      logic [W-1:0]             lv;
      logic [W-1:0][PREG_W-1:0] src0;
      logic [W-1:0][PREG_W-1:0] src1;
      logic [W-1:0][PREG_W-1:0] dst;
      logic [W-1:0][PW-1:0]     pl;
      Word  [W-1:0]             op0;
      Word  [W-1:0]             op1;
   } item_t;

   logic clk_in = 1'b0;
   logic rst_in, flush_in, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]             in_lane_valid, out_lane_valid;
   logic [W-1:0][PREG_W-1:0] in_src0, in_src1, in_dst, out_dst;
   logic [W-1:0][PW-1:0]     in_payload, out_payload;
   Word  [W-1:0]             out_op0, out_op1;
   RegisterFileReadRequest   rf_read0_req_out [W];
   RegisterFileReadRequest   rf_read1_req_out [W];
   RegisterFileReadResponse  rf_read0_resp_in [W];
   RegisterFileReadResponse  rf_read1_resp_in [W];
   RegisterFileWriteRequest  rf_write_req_in  [W];

   Word   rf [PHYSICAL_REGISTER_FILE_SIZE] = '{default: '0};
   item_t pend  [$];
   item_t exp_q [$];
   bit    known    = 1'b0;
   bit    last_acc = 1'b0;
   int    checks   = 0;
   int    errors   = 0;

   always #5 clk_in = ~clk_in;

   operand_fetch_stage dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .flush_in         (flush_in),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_lane_valid    (in_lane_valid),
      .in_src0          (in_src0),
      .in_src1          (in_src1),
      .in_dst           (in_dst),
      .in_payload       (in_payload),
      .rf_read0_req_out (rf_read0_req_out),
      .rf_read1_req_out (rf_read1_req_out),
      .rf_read0_resp_in (rf_read0_resp_in),
      .rf_read1_resp_in (rf_read1_resp_in),
      .rf_write_req_in  (rf_write_req_in),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_lane_valid   (out_lane_valid),
      .out_dst          (out_dst),
      .out_payload      (out_payload),
      .out_op0          (out_op0),
      .out_op1          (out_op1)
   );

   // Combinational-read, edge-written register file.
   always_comb begin
      for (int i = 0; i < W; i++) begin
         rf_read0_resp_in[i].data = rf[rf_read0_req_out[i].index];
         rf_read1_resp_in[i].data = rf[rf_read1_req_out[i].index];
      end
   end

   always @(posedge clk_in) begin
      for (int p = 0; p < W; p++) begin
         if (rf_write_req_in[p].write_enable) begin
            rf[rf_write_req_in[p].index] <= rf_write_req_in[p].data;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Architectural value of a register once this cycle's writebacks land.
   function automatic Word reg_value(input PregIndex idx);
      Word v;
      if (idx == '0) return '0;
      v = rf[idx];
      for (int p = 0; p < W; p++) begin
         if (rf_write_req_in[p].write_enable &&
             rf_write_req_in[p].index == idx) begin
            v = rf_write_req_in[p].data;
         end
      end
      return v;
   endfunction

   task automatic clear_writes();
      for (int p = 0; p < W; p++) rf_write_req_in[p] = '0;
   endtask

   task automatic set_write(input int p, input int idx, input Word d);
      rf_write_req_in[p].write_enable = 1'b1;
      rf_write_req_in[p].index        = PREG_W'(idx);
      rf_write_req_in[p].data         = d;
   endtask

   task automatic drive_bundle(input logic [W-1:0] lv, input int a0,
                               input int b0, input int a1, input int b1);
      in_valid      = 1'b1;
      in_lane_valid = lv;
      in_src0[0]    = PREG_W'(a0);
      in_src1[0]    = PREG_W'(b0);
      in_src0[1]    = PREG_W'(a1);
      in_src1[1]    = PREG_W'(b1);
      for (int i = 0; i < W; i++) begin
         in_dst[i]     = PREG_W'($urandom);
         in_payload[i] = {$urandom, $urandom};
      end
   endtask

   // Check handshake outputs for this cycle, then advance the model
   // across the coming edge and move to the next negedge.
   task automatic tick();
      bit    exp_rdy;
      bit    s2_free;
      item_t it;
      #1;
      exp_rdy = !flush_in &&
                (pend.size() == 0 || exp_q.size() == 0 || out_ready);
      if (known) begin
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         check("in_ready", 64'(in_ready), 64'(exp_rdy));
      end
      last_acc = 1'b0;
      if (!rst_in || flush_in) begin
         pend.delete();
         exp_q.delete();
         known = 1'b1;
      end else begin
         s2_free = (exp_q.size() == 0) || out_ready;
         if (pend.size() != 0 && s2_free) begin
            it = pend.pop_front();
            for (int l = 0; l < W; l++) begin
               it.op0[l] = it.lv[l] ? reg_value(it.src0[l]) : '0;
               it.op1[l] = it.lv[l] ? reg_value(it.src1[l]) : '0;
            end
            exp_q.push_back(it);
         end
         if (in_valid && exp_rdy) begin
            it.lv   = in_lane_valid;
            it.src0 = in_src0;
            it.src1 = in_src1;
            it.dst  = in_dst;
            it.pl   = in_payload;
            it.op0  = '0;
            it.op1  = '0;
            pend.push_back(it);
            last_acc = 1'b1;
         end
      end
      @(negedge clk_in);
   endtask

   initial begin : monitor
      item_t e;
      forever begin
         @(negedge clk_in);
         #2;
         if (rst_in === 1'b1 && flush_in === 1'b0 &&
             out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("lane_valid", 64'(out_lane_valid), 64'(e.lv));
               for (int l = 0; l < W; l++) begin
                  if (e.lv[l]) begin
                     check("dst", 64'(out_dst[l]), 64'(e.dst[l]));
                     check("payload", out_payload[l], e.pl[l]);
                     check("op0", out_op0[l], e.op0[l]);
                     check("op1", out_op1[l], e.op1[l]);
                  end
               end
            end
         end
      end
   end

   initial begin : driver
      rst_in        = 1'b0;
      flush_in      = 1'b0;
      in_valid      = 1'b0;
      out_ready     = 1'b0;
      in_lane_valid = '0;
      in_src0       = '0;
      in_src1       = '0;
      in_dst        = '0;
      in_payload    = '0;
      clear_writes();
      @(negedge clk_in);

      // reset held with a valid bundle presented, preload registers
      drive_bundle(2'b11, 1, 2, 3, 4);
      set_write(0, 5, 64'h11);
      set_write(1, 9, 64'h22);
      tick();
      clear_writes();
      tick();
      tick();

      // basic read
      rst_in    = 1'b1;
      out_ready = 1'b1;
      drive_bundle(2'b01, 5, 9, 0, 0);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();

      // bypass priority: both ports hit preg7 while S1 reads it
      drive_bundle(2'b01, 7, 7, 0, 0);
      tick();
      in_valid = 1'b0;
      set_write(0, 7, 64'hAA);
      set_write(1, 7, 64'hBB);
      tick();
      clear_writes();
      repeat (2) tick();

      // zero register ignores bypass
      drive_bundle(2'b11, 0, 5, 0, 9);
      tick();
      in_valid = 1'b0;
      set_write(0, 0, 64'hFF);
      set_write(1, 9, 64'h99);
      tick();
      clear_writes();
      repeat (2) tick();

      // backpressure with a write landing during the stall
      out_ready = 1'b0;
      drive_bundle(2'b11, 1, 2, 3, 4);
      tick();
      drive_bundle(2'b01, 3, 5, 0, 0);
      tick();
      drive_bundle(2'b10, 0, 0, 3, 9);
      tick();
      set_write(0, 3, 64'h55);
      tick();
      clear_writes();
      tick();
      out_ready = 1'b1;
      for (int k = 0; k < 10 && !last_acc; k++) tick();
      check("stalled_bundle_accepted", 64'(last_acc), 64'd1);
      in_valid = 1'b0;
      repeat (4) tick();

      // flush with both stages full
      out_ready = 1'b0;
      drive_bundle(2'b11, 5, 9, 3, 7);
      tick();
      drive_bundle(2'b11, 9, 5, 7, 3);
      tick();
      out_ready = 1'b1;
      flush_in  = 1'b1;
      drive_bundle(2'b11, 1, 1, 1, 1);
      tick();
      flush_in = 1'b0;
      in_valid = 1'b0;
      tick();
      drive_bundle(2'b11, 5, 9, 7, 3);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         rst_in    = ($urandom_range(0, 79) != 0);
         flush_in  = ($urandom_range(0, 29) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         drive_bundle(W'($urandom), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7));
         in_valid = ($urandom_range(0, 9) < 7);
         clear_writes();
         for (int p = 0; p < W; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               set_write(p, $urandom_range(0, 7), {$urandom, $urandom});
            end
         end
         tick();
      end

      rst_in    = 1'b1;
      flush_in  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clear_writes();
      repeat (5) tick();
      check("drained", 64'(exp_q.size() + pend.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Two-stage pipeline between the issue logic and execute.
- Accepts one issued bundle of SUPER_SCALAR_WIDTH micro-op lanes and drives the physical register file read ports from a registered copy of the bundle.
- Merges same-cycle write-port bypass into the operands and presents the bundle to execute through a registered valid/ready output.
- Bundles always move as a whole; lanes are never split.

Parameters:
- PAYLOAD_WIDTH, 64, opaque per-lane micro-op bits (opcode, imm, rob tag) carried through unchanged.
- SUPER_SCALAR_WIDTH, package constant, number of lanes.
- PHYSICAL_REGISTER_FILE_SIZE, package constant, number of pregs; PREG_W = $clog2(PHYSICAL_REGISTER_FILE_SIZE).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-low reset.
- flush_in  in  1  squash all in-flight bundles.
- in_valid  in  1  issued bundle valid.
- in_ready  out  1  stage can accept the bundle.
- in_lane_valid  in  [W-1:0]  per-lane occupancy.
- in_src0, in_src1, in_dst  in  [W-1:0][PREG_W-1:0]  physical register indices.
- in_payload  in  [W-1:0][PAYLOAD_WIDTH-1:0]  carried bits.
- rf_read0_req_out, rf_read1_req_out  out  RegisterFileReadRequest [W]  to register file.
- rf_read0_resp_in, rf_read1_resp_in  in  RegisterFileReadResponse [W]  combinational read data.
- rf_write_req_in  in  RegisterFileWriteRequest [W]  snooped writeback ports, used for bypass.
- out_valid  out  1  bundle with operands valid.
- out_ready  in  1  execute accepts the bundle.
- out_lane_valid, out_dst, out_payload  out  registered copies of the lane fields.
- out_op0, out_op1  out  [W-1:0] Word  resolved operands.

Behaviour:
- **Stage S1 (read).**
  - S1 captures the input bundle on in_valid && in_ready.
  - Read requests are driven combinationally from the S1 registers; lanes that are not valid drive index 0.
- **Stage S2 (output).**
  - S2 captures the S1 bundle plus resolved operands when s1_valid && (!s2_valid || out_ready).
  - All out_* signals come from S2 registers: no combinational path from the inputs to the outputs.
- **Handshake.**
  - in_ready = !s1_valid || s1_advance.
  - out_valid = s2_valid; a transfer occurs on out_valid && out_ready.
  - Full throughput: one bundle per cycle when out_ready is held high.
  - Latency: a bundle accepted at edge N appears with out_valid=1 after edge N+1.
- **Stall.**
  - While S1 is held, it re-reads the register file every cycle, so writes that land during the stall are picked up.
  - S2 contents and operands are frozen while out_valid && !out_ready.
- **Operand resolution, per lane and per source, in priority order:**
  1. If the index is 0, the operand is 0; bypass is ignored.
  2. Otherwise, any rf_write_req_in port with write_enable and a matching register index supplies its data. If several ports match, the highest port index wins.
  3. Otherwise, the register-file response is used.
- **Flush.**
  - On the edge where flush_in=1, s1_valid and s2_valid clear.
  - The input bundle presented that cycle is dropped, and in_ready is forced to 0 during the flush cycle.
  - A bundle at the output that same cycle does not transfer, even if out_ready=1.
- **Reset.**
  - rst_in=0 at an edge clears s1_valid and s2_valid, even mid-stall; data registers are don't-care.
  - After reset: out_valid=0 and in_ready=1 on the first cycle with rst_in=1.
  - Outputs while out_valid=0 are undefined except out_valid itself.
- **Lane masking.** A lane with lane_valid=0 propagates lane_valid=0; its operands are don't-care.

Decomposition:
- Shared package: SUPER_SCALAR_WIDTH, PHYSICAL_REGISTER_FILE_SIZE, Word, RegisterFileRead/WriteRequest/Response, plus a new IssuedUop struct {lane_valid, src0, src1, dst, payload} and a PregIndex typedef.
- One sub-module, operand_bypass_mux: combinational, for one operand. Inputs are the index, the register-file data and the write ports; the output is the resolved Word. Instantiated 2×W times.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles with in_valid=1 -> out_valid=0 throughout; in_ready=1 on the first cycle after release.
- Basic read: preg5=0x11, preg9=0x22; issue lane0 src0=5, src1=9, out_ready=1 -> two edges later out_valid=1, out_op0=0x11, out_op1=0x22.
- Bypass priority: S1 reads preg7 (stale value 0x0) while write port 0 writes 0xAA and port 1 writes 0xBB to preg7 in the same cycle -> out_op0=0xBB.
- Zero register: src0=0 while a write port writes 0xFF to preg0 -> out_op0=0.
- Backpressure: issue 3 bundles back to back with out_ready=0 -> in_ready falls after 2 bundles. Write preg3=0x55 during the stall. On release, the bundles emerge in order without loss, and the S1 bundle reading preg3 returns 0x55.
- Flush: with both stages full and out_ready=1, pulse flush_in -> no transfer that cycle, out_valid=0 on the next cycle, and the next issued bundle flows normally.
